fft_reorder_buf: RTL and testbench
==================================

// Module: fft_reorder_buf
// PURPOSE
//  Receive-side buffer between CP removal and the FFT core. Collects N_FFT complex
//  samples per OFDM symbol into a ping-pong memory. Streams each completed symbol to
//  the FFT, in bit-reversed order when BITREV_EN is defined.
//  Lets the FFT stall without losing data, and flags overflow.
// PARAMETERS
//  DW     16  bit width of each real/imag component
//  N_FFT  64  samples per symbol (power of two)
//  LOG2N  6   log2(N_FFT); bank address width
// PORTS
//  CLK_I     in   1    system clock; all logic on rising edge
//  RST_I     in   1    synchronous, active-high reset
//  DAT_I_r   in   DW   input sample, real (two's complement)
//  DAT_I_i   in   DW   input sample, imag
//  ACK_I     in   1    input valid strobe; one sample per cycle where high
//  STALL_I   in   1    FFT not ready; freezes output stream
//  DAT_O_r   out  DW   output sample, real
//  DAT_O_i   out  DW   output sample, imag
//  ACK_O     out  1    DAT_O valid this cycle
//  SOF_O     out  1    high with ACK_O on first sample of each symbol
//  OVF_O     out  1    sticky: a sample was dropped because no bank was free
// BEHAVIOUR
//  - Reset: all outputs 0. Write/read counters 0. Both bank-full flags 0. wr_bank=0, rd_bank=0.
//    RAM contents are not cleared. Reset mid-symbol discards partial and pending symbols.
//  - Writer: on ACK_I=1, if full[wr_bank]=0, write to {wr_bank,wr_cnt}, then wr_cnt++.
//    If wr_cnt==N_FFT-1: set full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
//  - Writer drop: on ACK_I=1 with full[wr_bank]=1, discard the sample, set OVF_O=1
//    (cleared only by RST_I), and hold wr_cnt.
//  - Reader FSM: IDLE -> STREAM when full[rd_bank]=1 (registered flag).
//    In STREAM, each cycle with STALL_I=0: read address {rd_bank,addr(rd_cnt)}, then rd_cnt++.
//    After issuing rd_cnt==N_FFT-1: clear full[rd_bank], toggle rd_bank, and wrap rd_cnt.
//    Then go to STREAM if full of the new rd_bank is set, else go to IDLE. Back-to-back symbols have no bubble.
//  - Read latency 1: RAM output is registered, giving DAT_O/ACK_O one cycle after the address.
//    SOF_O is asserted for the rd_cnt==0 read.
//  - Latency: last sample written at edge k -> first ACK_O=1 in cycle k+2.
//  - STALL_I=1: read address, RAM read enable, DAT_O, ACK_O and SOF_O all hold their values.
//    No sample is repeated or skipped. A stall does not block the writer unless both banks are full.
//  - Simultaneous events: a flag set and clear on the same bank in one edge cannot occur.
//    A bank freed at edge t is writable from cycle t+1. Writer and reader touching the same
//    bank is impossible by construction.
//  - ACK_O=0 implies DAT_O holds its last value. No arithmetic is performed; data passes bit-exact.
// CONFIGURATION
//  BITREV_EN defined:   addr(rd_cnt) = bit-reverse of rd_cnt over LOG2N bits, giving DIT input order.
//  BITREV_EN undefined: addr(rd_cnt) = rd_cnt, giving natural order (plain ping-pong FIFO).
//  Latency and handshake are identical in both configurations.
// STRUCTURE
//  ofdm_pkg: DW, N_FFT, LOG2N defaults, complex sample struct {re,im}, bitrev() function.
//  Sub-module fft_reorder_ram: simple dual-port sync RAM, 2*N_FFT x 2*DW.
//    Write port has no enable gating beyond we. Read port has re and a registered output.
//  Top level holds the writer counter, bank flags and reader FSM.
// TESTING
//  1 Ramp 0..63 on re (im = ~re), ACK_I continuous, STALL_I=0
//    -> ACK_O rises 2 cycles after sample 63. BITREV_EN: output re = 0,32,16,48,8,...
//    Natural order: 0..63. SOF_O only with the first sample.
//  2 Three symbols back-to-back, no gaps
//    -> 192 contiguous ACK_O cycles. SOF_O at offsets 0, 64 and 128. OVF_O stays 0.
//  3 STALL_I high for 10 cycles mid-stream (at output index 20)
//    -> DAT_O frozen at index-20 value. Resumes at 21. No duplicate or missing sample.
//  4 STALL_I held high while 2.5 symbols arrive
//    -> the first 128 samples are buffered. Samples 128+ are dropped and OVF_O=1 stays high.
//    On release, exactly two symbols stream out.
//  5 RST_I pulsed at input sample 30
//    -> outputs 0 the next cycle. The following 64 samples form a clean symbol, output per test 1.
//  6 Gapped ACK_I (1 cycle on, 1 cycle off)
//    -> output is correct. ACK_O bursts of 64 once each bank fills.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM receive-path types: sample widths, complex sample struct,
// reorder-reader state encoding and the bit-reverse helper.
package ofdm_pkg;

    localparam int DW    = 16;
    localparam int N_FFT = 64;
    localparam int LOG2N = 6;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } sample_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port synchronous RAM holding both ping-pong banks; the read
// data register clears on reset so the buffer outputs start at zero.
module fft_reorder_ram #(
    parameter int AW = 7,
    parameter int WW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Holding rdata when re is low is what freezes DAT_O during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_reorder_buf.sv
// Ping-pong symbol buffer between CP removal and the FFT. Define BITREV_EN
// to stream each symbol in bit-reversed (DIT input) order instead of natural order.
module fft_reorder_buf
    import ofdm_pkg::*;
#(
    parameter int DW    = ofdm_pkg::DW,
    parameter int N_FFT = ofdm_pkg::N_FFT,
    parameter int LOG2N = ofdm_pkg::LOG2N
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I_r,
    input  logic [DW-1:0] DAT_I_i,
    input  logic          ACK_I,
    input  logic          STALL_I,
    output logic [DW-1:0] DAT_O_r,
    output logic [DW-1:0] DAT_O_i,
    output logic          ACK_O,
    output logic          SOF_O,
    output logic          OVF_O,
    output rd_state_e     dbg_state
);

    // Handshake: ACK_I has no backpressure, a sample arrives on every edge where it is high.
    // On the output side a sample transfers on an edge where ACK_O=1 and STALL_I=0;
    // while STALL_I=1 the presented sample (DAT_O, ACK_O, SOF_O) is held unchanged.

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N_FFT - 1);

    logic             wr_bank, rd_bank;
    logic [LOG2N-1:0] wr_cnt, rd_cnt, rd_addr;
    logic [1:0]       full, set_mask, clr_mask;
    logic             ovf, ack_q, sof_q;
    logic             wr_en, wr_last, rd_en, rd_last;
    rd_state_e        state, state_nxt;
    sample_t          wr_sample, rd_sample;

    assign wr_sample = '{re: DAT_I_r, im: DAT_I_i};

`ifdef BITREV_EN
    assign rd_addr = bitrev(rd_cnt);
`else
    assign rd_addr = rd_cnt;
`endif

    // A freshly filled bank is read in the cycle it is first seen full, which is
    // what makes consecutive symbols stream without a bubble.
    always_comb begin
        wr_en     = ACK_I && !full[wr_bank];
        wr_last   = wr_en && (wr_cnt == LAST);
        rd_en     = !STALL_I && ((state == RD_STREAM) || full[rd_bank]);
        rd_last   = rd_en && (rd_cnt == LAST);
        set_mask  = '0;
        clr_mask  = '0;
        state_nxt = state;
        if (wr_last) set_mask[wr_bank] = 1'b1;
        if (rd_last) clr_mask[rd_bank] = 1'b1;
        if (rd_last) begin
            state_nxt = full[~rd_bank] ? RD_STREAM : RD_IDLE;
        end else if (full[rd_bank]) begin
            state_nxt = RD_STREAM;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            full    <= '0;
            ovf     <= 1'b0;
            ack_q   <= 1'b0;
            sof_q   <= 1'b0;
            state   <= RD_IDLE;
        end else begin
            full  <= (full | set_mask) & ~clr_mask;
            state <= state_nxt;
            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) wr_bank <= ~wr_bank;
            end
            if (ACK_I && full[wr_bank]) begin
                ovf <= 1'b1;
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) rd_bank <= ~rd_bank;
            end
            if (!STALL_I) begin
                ack_q <= rd_en;
                sof_q <= rd_en && (rd_cnt == '0);
            end
        end
    end

    fft_reorder_ram #(
        .AW(LOG2N + 1),
        .WW(2 * DW)
    ) u_ram (
        .clk  (CLK_I),
        .rst  (RST_I),
        .we   (wr_en),
        .waddr({wr_bank, wr_cnt}),
        .wdata(wr_sample),
        .re   (rd_en),
        .raddr({rd_bank, rd_addr}),
        .rdata(rd_sample)
    );

    assign DAT_O_r   = rd_sample.re;
    assign DAT_O_i   = rd_sample.im;
    assign ACK_O     = ack_q;
    assign SOF_O     = sof_q;
    assign OVF_O     = ovf;
    assign dbg_state = state;

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf: symbol-level reference model with an expected queue,
// negedge output monitor, and one task per scenario.
module tb_fft_reorder_buf;

    localparam int DW    = 16;
    localparam int N     = 64;
    localparam int LOG2N = 6;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ack_i, stall;
    logic [DW-1:0] din_r, din_i;
    logic [DW-1:0] dat_o_r, dat_o_i;
    logic          ack_o, sof_o, ovf_o;
    ofdm_pkg::rd_state_e dbg_state;

    fft_reorder_buf dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .DAT_I_r  (din_r),
        .DAT_I_i  (din_i),
        .ACK_I    (ack_i),
        .STALL_I  (stall),
        .DAT_O_r  (dat_o_r),
        .DAT_O_i  (dat_o_i),
        .ACK_O    (ack_o),
        .SOF_O    (sof_o),
        .OVF_O    (ovf_o),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: whole symbols are collected, then queued in output order
    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] sym_buf[$];
    logic [2*DW-1:0] exp_s;
    int out_idx = 0;
    int run = 0;
    int max_run = 0;
    bit exp_sof;

    function automatic int out_order(input int k);
`ifdef BITREV_EN
        int x = k;
        int r = 0;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
`else
        return k;
`endif
    endfunction

    task automatic model_push(input logic [2*DW-1:0] s);
        sym_buf.push_back(s);
        if (sym_buf.size() == N) begin
            for (int k = 0; k < N; k++) exp_q.push_back(sym_buf[out_order(k)]);
            sym_buf.delete();
        end
    endtask

    // driver tasks
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input bit keep);
        ack_i = 1'b1;
        din_r = re;
        din_i = im;
        if (keep) model_push({re, im});
        @(posedge clk);
        #1;
        ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int budget, output int left);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            idle(1);
            c++;
        end
        idle(6);
        left = exp_q.size();
    endtask

    // scoreboard: a sample is consumed on the edge following a negedge with ACK_O=1, STALL_I=0
    always @(negedge clk) begin
        if (ack_o === 1'b1) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (!rst && ack_o === 1'b1 && stall === 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL out_data: got unexpected sample %h, required none", {dat_o_r, dat_o_i});
            end else begin
                exp_s = exp_q.pop_front();
                if ({dat_o_r, dat_o_i} !== exp_s)
                    $display("FAIL out_data[%0d]: got %h, required %h", out_idx, {dat_o_r, dat_o_i}, exp_s);
                else
                    n_pass++;
            end
            exp_sof = (out_idx % N == 0);
            n_checks++;
            if (sof_o !== exp_sof)
                $display("FAIL sof[%0d]: got %b, required %b", out_idx, sof_o, exp_sof);
            else
                n_pass++;
            out_idx++;
        end
    end

    task automatic test_reset();
        rst = 1'b1; ack_i = 1'b0; stall = 1'b0; din_r = '0; din_i = '0;
        idle(2);
        n_checks++;
        if ({ack_o, sof_o, ovf_o} !== 3'b000)
            $display("FAIL reset_flags: got %b, required 000", {ack_o, sof_o, ovf_o});
        else n_pass++;
        n_checks++;
        if ({dat_o_r, dat_o_i} !== '0)
            $display("FAIL reset_data: got %h, required 0", {dat_o_r, dat_o_i});
        else n_pass++;
        n_checks++;
        if (dbg_state !== ofdm_pkg::RD_IDLE)
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, ofdm_pkg::RD_IDLE);
        else n_pass++;
        rst = 1'b0;
        out_idx = 0;
        idle(2);
    endtask

    task automatic test_ramp();
        int left;
        for (int i = 0; i < N; i++) send(DW'(i), ~DW'(i), 1'b1);
        n_checks++;
        if (ack_o !== 1'b0) $display("FAIL ramp_latency_early: ack_o got %b, required 0", ack_o);
        else n_pass++;
        idle(1);
        n_checks++;
        if (ack_o !== 1'b1 || sof_o !== 1'b1)
            $display("FAIL ramp_latency: ack/sof got %b%b, required 11", ack_o, sof_o);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ofdm_pkg::RD_STREAM)
            $display("FAIL ramp_state: got %0d, required %0d", dbg_state, ofdm_pkg::RD_STREAM);
        else n_pass++;
        drain(400, left);
        n_checks++;
        if (left != 0) $display("FAIL ramp_drain: %0d samples outstanding, required 0", left);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int left;
        max_run = 0;
        for (int i = 0; i < 3 * N; i++) send(DW'($urandom()), DW'($urandom()), 1'b1);
        drain(600, left);
        n_checks++;
        if (left != 0) $display("FAIL b2b_drain: %0d samples outstanding, required 0", left);
        else n_pass++;
        n_checks++;
        if (max_run != 3 * N) $display("FAIL b2b_contiguous: ack run got %0d, required %0d", max_run, 3 * N);
        else n_pass++;
        n_checks++;
        if (ovf_o !== 1'b0) $display("FAIL b2b_ovf: got %b, required 0", ovf_o);
        else n_pass++;
    endtask

    task automatic test_stall();
        int left;
        int base;
        int c;
        logic [2*DW-1:0] frozen;
        logic [2*DW-1:0] want;
        base = out_idx;
        for (int i = 0; i < N; i++) send(DW'($urandom()), DW'($urandom()), 1'b1);
        c = 0;
        while (!(ack_o === 1'b1 && out_idx == base + 20) && c < 300) begin
            idle(1);
            c++;
        end
        n_checks++;
        if (c >= 300) $display("FAIL stall_reach: index 20 not reached, got index %0d", out_idx - base);
        else n_pass++;
        stall = 1'b1;
        frozen = {dat_o_r, dat_o_i};
        want = (exp_q.size() != 0) ? exp_q[0] : '0;
        n_checks++;
        if (frozen !== want) $display("FAIL stall_value: got %h, required %h", frozen, want);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            n_checks++;
            if ({dat_o_r, dat_o_i} !== frozen || ack_o !== 1'b1)
                $display("FAIL stall_hold[%0d]: got %h ack %b, required %h ack 1",
                         i, {dat_o_r, dat_o_i}, ack_o, frozen);
            else n_pass++;
        end
        stall = 1'b0;
        drain(300, left);
        n_checks++;
        if (left != 0) $display("FAIL stall_drain: %0d samples outstanding, required 0", left);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int left;
        int base;
        stall = 1'b1;
        base = out_idx;
        for (int i = 0; i < 5 * N / 2; i++) send(DW'($urandom()), DW'($urandom()), i < 2 * N);
        n_checks++;
        if (ovf_o !== 1'b1 || ack_o !== 1'b0)
            $display("FAIL ovf_set: ovf/ack got %b%b, required 10", ovf_o, ack_o);
        else n_pass++;
        stall = 1'b0;
        drain(600, left);
        n_checks++;
        if (left != 0 || out_idx - base != 2 * N)
            $display("FAIL ovf_release: streamed %0d, outstanding %0d, required %0d and 0",
                     out_idx - base, left, 2 * N);
        else n_pass++;
        n_checks++;
        if (ovf_o !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", ovf_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int left;
        for (int i = 0; i < 30; i++) send(DW'(i + 100), DW'($urandom()), 1'b1);
        rst = 1'b1;
        ack_i = 1'b1;
        din_r = DW'(30);
        idle(1);
        rst = 1'b0;
        ack_i = 1'b0;
        sym_buf.delete();
        out_idx = 0;
        n_checks++;
        if ({ack_o, sof_o, ovf_o} !== 3'b000 || {dat_o_r, dat_o_i} !== '0)
            $display("FAIL midreset_outputs: got flags %b data %h, required 000 and 0",
                     {ack_o, sof_o, ovf_o}, {dat_o_r, dat_o_i});
        else n_pass++;
        for (int i = 0; i < N; i++) send(DW'(i), ~DW'(i), 1'b1);
        drain(400, left);
        n_checks++;
        if (left != 0) $display("FAIL midreset_drain: %0d samples outstanding, required 0", left);
        else n_pass++;
    endtask

    task automatic test_gapped();
        int left;
        max_run = 0;
        for (int i = 0; i < 2 * N; i++) begin
            send(DW'($urandom()), DW'($urandom()), 1'b1);
            idle(1);
        end
        drain(600, left);
        n_checks++;
        if (left != 0) $display("FAIL gapped_drain: %0d samples outstanding, required 0", left);
        else n_pass++;
        n_checks++;
        if (max_run != N) $display("FAIL gapped_burst: ack run got %0d, required %0d", max_run, N);
        else n_pass++;
        n_checks++;
        if (ovf_o !== 1'b0) $display("FAIL gapped_ovf: got %b, required 0", ovf_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_gapped();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1);
    end

endmodule
